ex_mod_krr_chk: RTL and testbench
=================================

EX_MOD_KRR_CHK -- requirements
Module: ex_mod_krr_chk

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: opUCmd  in  8  and opUIxt  in  8, the same micro-op the keyring encoder receives.
REQ-003 SHALL have ports: exHold  in  1  pipeline stall; regInDlrE  in  66  and regInDhrE  in  66, the encoder's registered outputs.
REQ-004 SHALL have ports: trapAck  in  1  trap consumed by the trap unit.
REQ-005 SHALL have outputs:
- regOutDlr  out  64  checked data
- regOutDhr  out  64  parity word
- regOutValid  out  1  result strobe
- regOutTag  out  2  result tag
REQ-006 SHALL have outputs:
- trapReq  out  1
- trapCode  out  16
- krrLocked  out  1
- krrFailCnt  out  4

Function
REQ-007 SHALL hold opUCmd/opUIxt in a one-stage delay register, updated only when exHold=0, so that the op lines up with the encoder data (which lags by one cycle).
REQ-008 SHALL decode the delayed op as LDEKRR, LDEENC or LDEKEY only when opUCmd[5:0]==JX2_UCMD_OP_IXT and opUIxt[5:0] equals the matching JX2_UCIX_IXT_* code.
REQ-009 SHALL register all data outputs, giving a total latency of 2 cycles from the op issue cycle to the regOutValid=1 cycle.
REQ-010 On a delayed LDEKRR with regInDlrE[65:64]==2'b10 and state not LOCKED, SHALL:
- output regOutDlr=regInDlrE[63:0], regOutTag=2'b10 and regOutValid=1 for one cycle;
- clear krrFailCnt to 0.
REQ-011 On a delayed LDEKRR with any other tag, or while LOCKED, SHALL:
- output regOutDlr=0, regOutTag=2'b00 and regOutValid=1;
- count the event as a failure.
REQ-012 On a delayed LDEENC, SHALL output regOutDlr=regInDlrE[63:0], regOutDhr=regInDhrE[63:0], regOutTag=2'b00 and regOutValid=1.
REQ-013 On a delayed LDEKEY or any other op, SHALL output regOutValid=0, regOutDlr=0 and regOutDhr=0.
REQ-014 SHALL implement the state machine IDLE, FAULT, LOCKWAIT, LOCKED:
- a failure in IDLE goes to FAULT;
- FAULT returns to IDLE on trapAck;
- the lockout-threshold failure goes to LOCKWAIT;
- LOCKWAIT goes to LOCKED on trapAck;
- LOCKED exits only on reset.
REQ-015 In FAULT, SHALL drive trapReq=1 and trapCode=16'h0C1F.
REQ-016 In LOCKWAIT, SHALL drive trapReq=1 and trapCode=16'h0C1E.
REQ-017 In IDLE and LOCKED, SHALL drive trapReq=0 and trapCode=0.
REQ-018 SHALL keep trapReq and trapCode stable until trapAck; trapAck while trapReq=0 SHALL be ignored.
REQ-019 A failure while trapReq=1 SHALL NOT raise a new trap or change trapCode, but SHALL still be counted.
REQ-020 A failure in the same cycle as trapAck in FAULT SHALL keep the state in FAULT, so trapReq stays 1.
REQ-021 While exHold=1, SHALL freeze:
- the delay register;
- all outputs, including regOutValid;
- the failure counter and the FSM state (trapAck is still accepted).

Reset
REQ-022 On reset=1 at a clock edge, SHALL clear the delay register, all outputs and krrFailCnt, and enter IDLE.
REQ-023 Reset SHALL take effect regardless of exHold and mid-trap, dropping any pending trapReq without needing an ack.

Configuration
REQ-024 With JX2_KRR_LOCKOUT_EN defined, SHALL behave as follows:
- krrFailCnt increments on each failure, saturating at 15;
- the failure that makes the count reach 8 enters LOCKWAIT;
- krrLocked=1 in LOCKWAIT and LOCKED.
REQ-025 Without JX2_KRR_LOCKOUT_EN, SHALL behave as follows:
- there is no counter; krrFailCnt=0 and krrLocked=0 constantly;
- LOCKWAIT and LOCKED are unreachable;
- every failure follows the IDLE/FAULT rules only.

Verification
REQ-026 LDEKRR issued at cycle 0 with encoder tag 2'b10 and data 0x1122334455667788 -> at cycle 2, regOutValid=1, regOutTag=2'b10, regOutDlr=0x1122334455667788, trapReq=0.
REQ-027 LDEKRR with tag 2'b00 -> cycle 2: regOutDlr=0, regOutTag=2'b00; trapReq=1 with trapCode=0x0C1F, held 5 cycles until trapAck, deasserted the following cycle.
REQ-028 Fail-ack sequence repeated 8 times (macro defined) -> krrFailCnt=8, krrLocked=1, trapCode=0x0C1E. After ack, a tag-2'b10 LDEKRR still returns regOutDlr=0 with no new trap.
REQ-029 LDEENC with exHold=1 for 3 cycles after issue -> outputs frozen for the 3 cycles, then regOutDhr equals regInDhrE[63:0] once the hold releases.
REQ-030 Second failure arriving in the same cycle as trapAck -> trapReq remains 1. Then reset asserted mid-FAULT -> the next cycle shows trapReq=0, krrFailCnt=0, state IDLE.

Source files
------------

// File: rtl/ex_mod_krr_chk.sv
// Keyring result checker: lines a delayed micro-op up with the encoder outputs, gates keyring loads and raises traps.
// Optional lockout counter/state enabled by JX2_KRR_LOCKOUT_EN.
module ex_mod_krr_chk (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  opUCmd,
  input  logic [7:0]  opUIxt,
  input  logic        exHold,
  input  logic [65:0] regInDlrE,
  input  logic [65:0] regInDhrE,
  input  logic        trapAck,
  output logic [63:0] regOutDlr,
  output logic [63:0] regOutDhr,
  output logic        regOutValid,
  output logic [1:0]  regOutTag,
  output logic        trapReq,
  output logic [15:0] trapCode,
  output logic        krrLocked,
  output logic [3:0]  krrFailCnt
);

  localparam logic [5:0]  JX2_UCMD_OP_IXT        = 6'h2E;
  localparam logic [5:0]  JX2_UCIX_IXT_LDEKRR    = 6'h11;
  localparam logic [5:0]  JX2_UCIX_IXT_LDEENC    = 6'h12;
  localparam logic [5:0]  JX2_UCIX_IXT_LDEKEY    = 6'h13;
  localparam logic [15:0] TRAP_KRR_FAULT         = 16'h0C1F;
  localparam logic [15:0] TRAP_KRR_LOCK          = 16'h0C1E;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FAULT    = 2'd1,
    ST_LOCKWAIT = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, ixt_q;
  logic [63:0] dlr_q, dlr_d, dhr_q, dhr_d;
  logic        valid_q, valid_d;
  logic [1:0]  tag_q, tag_d;
  logic        trap_req_q, trap_req_d;
  logic [15:0] trap_code_q, trap_code_d;

  logic is_ixt, op_krr, op_enc, op_key;
  logic krr_ok, krr_fail, fail_ev;
  logic lock_hit, lock_pend;

  assign is_ixt   = (cmd_q[5:0] == JX2_UCMD_OP_IXT);
  assign op_krr   = is_ixt && (ixt_q[5:0] == JX2_UCIX_IXT_LDEKRR);
  assign op_enc   = is_ixt && (ixt_q[5:0] == JX2_UCIX_IXT_LDEENC);
  assign op_key   = is_ixt && (ixt_q[5:0] == JX2_UCIX_IXT_LDEKEY);
  assign krr_ok   = op_krr && (regInDlrE[65:64] == 2'b10) && (state_q != ST_LOCKED);
  assign krr_fail = op_krr && !krr_ok;
  assign fail_ev  = !exHold && krr_fail;

`ifdef JX2_KRR_LOCKOUT_EN
  logic [3:0] cnt_q, cnt_inc;

  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign lock_hit  = (cnt_inc >= 4'd8);
  assign lock_pend = (cnt_q >= 4'd8);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (!exHold) begin
      if (krr_ok)        cnt_q <= 4'd0;
      else if (krr_fail) cnt_q <= cnt_inc;
    end
  end

  assign krrFailCnt = cnt_q;
  assign krrLocked  = (state_q == ST_LOCKWAIT) || (state_q == ST_LOCKED);
`else
  assign lock_hit   = 1'b0;
  assign lock_pend  = 1'b0;
  assign krrFailCnt = 4'd0;
  assign krrLocked  = 1'b0;
`endif

  // A trap already pending absorbs further failures; a threshold crossed
  // while in FAULT surfaces as the lockout trap once the fault is acked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (fail_ev) state_d = lock_hit ? ST_LOCKWAIT : ST_FAULT;
      ST_FAULT:    if (fail_ev) state_d = ST_FAULT;
                   else if (trapAck) state_d = lock_pend ? ST_LOCKWAIT : ST_IDLE;
      ST_LOCKWAIT: if (trapAck) state_d = ST_LOCKED;
      ST_LOCKED:   state_d = ST_LOCKED;
      default:     state_d = ST_IDLE;
    endcase
    trap_req_d  = (state_d == ST_FAULT) || (state_d == ST_LOCKWAIT);
    trap_code_d = 16'h0000;
    if (state_d == ST_FAULT)    trap_code_d = TRAP_KRR_FAULT;
    if (state_d == ST_LOCKWAIT) trap_code_d = TRAP_KRR_LOCK;
  end

  always_comb begin
    dlr_d   = 64'd0;
    dhr_d   = 64'd0;
    valid_d = 1'b0;
    tag_d   = 2'b00;
    if (krr_ok) begin
      dlr_d   = regInDlrE[63:0];
      tag_d   = 2'b10;
      valid_d = 1'b1;
    end else if (krr_fail) begin
      valid_d = 1'b1;
    end else if (op_enc) begin
      dlr_d   = regInDlrE[63:0];
      dhr_d   = regInDhrE[63:0];
      valid_d = 1'b1;
    end else if (op_key) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      trap_req_q  <= 1'b0;
      trap_code_q <= 16'h0000;
      cmd_q       <= 8'd0;
      ixt_q       <= 8'd0;
      dlr_q       <= 64'd0;
      dhr_q       <= 64'd0;
      valid_q     <= 1'b0;
      tag_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      trap_req_q  <= trap_req_d;
      trap_code_q <= trap_code_d;
      if (!exHold) begin
        cmd_q   <= opUCmd;
        ixt_q   <= opUIxt;
        dlr_q   <= dlr_d;
        dhr_q   <= dhr_d;
        valid_q <= valid_d;
        tag_q   <= tag_d;
      end
    end
  end

  assign regOutDlr   = dlr_q;
  assign regOutDhr   = dhr_q;
  assign regOutValid = valid_q;
  assign regOutTag   = tag_q;
  assign trapReq     = trap_req_q;
  assign trapCode    = trap_code_q;

  logic unused_bits;
  assign unused_bits = ^{regInDhrE[65:64], cmd_q[7:6], ixt_q[7:6]};

endmodule

// File: tb/tb_ex_mod_krr_chk.sv
// Directed bench for ex_mod_krr_chk with a scoreboard of expected result-bus values.
// Lockout expectations switch with JX2_KRR_LOCKOUT_EN.
module tb_ex_mod_krr_chk;

  localparam logic [5:0] OP_IXT = 6'h2E;
  localparam logic [5:0] IX_KRR = 6'h11;
  localparam logic [5:0] IX_ENC = 6'h12;
  localparam logic [5:0] IX_KEY = 6'h13;

`ifdef JX2_KRR_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  opUCmd, opUIxt;
  logic        exHold;
  logic [65:0] regInDlrE, regInDhrE;
  logic        trapAck;
  logic [63:0] regOutDlr, regOutDhr;
  logic        regOutValid;
  logic [1:0]  regOutTag;
  logic        trapReq;
  logic [15:0] trapCode;
  logic        krrLocked;
  logic [3:0]  krrFailCnt;

  ex_mod_krr_chk dut (
    .clock(clock), .reset(reset), .opUCmd(opUCmd), .opUIxt(opUIxt),
    .exHold(exHold), .regInDlrE(regInDlrE), .regInDhrE(regInDhrE),
    .trapAck(trapAck), .regOutDlr(regOutDlr), .regOutDhr(regOutDhr),
    .regOutValid(regOutValid), .regOutTag(regOutTag), .trapReq(trapReq),
    .trapCode(trapCode), .krrLocked(krrLocked), .krrFailCnt(krrFailCnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [1:0]  tag;
    logic [63:0] dlr;
    logic [63:0] dhr;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic exp_t mk(logic v, logic [1:0] t, logic [63:0] l, logic [63:0] h);
    exp_t e;
    e.valid = v; e.tag = t; e.dlr = l; e.dhr = h;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, " valid"}, {63'd0, regOutValid}, {63'd0, e.valid});
      chk({name, " tag"},   {62'd0, regOutTag},   {62'd0, e.tag});
      chk({name, " dlr"},   regOutDlr, e.dlr);
      chk({name, " dhr"},   regOutDhr, e.dhr);
    end
  endtask

  task automatic chk_trap(input string name, input logic req, input logic [15:0] code);
    chk({name, " trapReq"},  {63'd0, trapReq},  {63'd0, req});
    chk({name, " trapCode"}, {48'd0, trapCode}, {48'd0, code});
  endtask

  // Op presented for one cycle, encoder data on the next, result checked two edges after issue.
  task automatic run_op(input string name, input logic [7:0] cmd, input logic [7:0] ixt,
                        input logic [1:0] etag, input logic [63:0] dl, input logic [63:0] dh,
                        input logic ack, input exp_t e);
    opUCmd = cmd; opUIxt = ixt;
    tick();
    opUCmd = 8'd0; opUIxt = 8'd0;
    regInDlrE = {etag, dl}; regInDhrE = {2'b11, dh}; trapAck = ack;
    sb.push_back(e);
    tick();
    trapAck = 1'b0; regInDlrE = '0; regInDhrE = '0;
    pop_check(name);
  endtask

  localparam logic [7:0] CMD = {2'b00, OP_IXT};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a_dl, a_dh, b_dh;
    reset = 1'b1; exHold = 1'b1; trapAck = 1'b0;
    opUCmd = 8'd0; opUIxt = 8'd0; regInDlrE = '0; regInDhrE = '0;
    tick(); tick();
    chk("rst valid", {63'd0, regOutValid}, 64'd0);
    chk("rst dlr", regOutDlr, 64'd0);
    chk("rst dhr", regOutDhr, 64'd0);
    chk_trap("rst", 1'b0, 16'h0000);
    chk("rst cnt", {60'd0, krrFailCnt}, 64'd0);
    chk("rst locked", {63'd0, krrLocked}, 64'd0);
    reset = 1'b0; exHold = 1'b0;
    tick();

    run_op("krr_ok", CMD, {2'b00, IX_KRR}, 2'b10, 64'h1122334455667788, 64'hAAAA, 1'b0,
           mk(1'b1, 2'b10, 64'h1122334455667788, 64'd0));
    chk_trap("krr_ok", 1'b0, 16'h0000);
    tick();
    chk("krr_ok one-shot", {63'd0, regOutValid}, 64'd0);

    a_dl = 64'hDEADBEEF00C0FFEE; a_dh = 64'h0123456789ABCDEF;
    run_op("enc", CMD, {2'b00, IX_ENC}, 2'b01, a_dl, a_dh, 1'b0, mk(1'b1, 2'b00, a_dl, a_dh));
    run_op("key", CMD, {2'b00, IX_KEY}, 2'b10, 64'h55, 64'h66, 1'b0, mk(1'b0, 2'b00, 64'd0, 64'd0));
    run_op("bad_cmd", {2'b00, 6'h2F}, {2'b00, IX_KRR}, 2'b10, 64'h77, 64'h0, 1'b0,
           mk(1'b0, 2'b00, 64'd0, 64'd0));
    run_op("upper_bits", 8'hC0 | CMD, 8'h40 | {2'b00, IX_ENC}, 2'b00, 64'h99, 64'h88, 1'b0,
           mk(1'b1, 2'b00, 64'h99, 64'h88));
    chk_trap("no_trap", 1'b0, 16'h0000);

    trapAck = 1'b1; tick(); trapAck = 1'b0;
    chk_trap("idle_ack", 1'b0, 16'h0000);

    run_op("krr_fail", CMD, {2'b00, IX_KRR}, 2'b00, 64'h1122334455667788, 64'd0, 1'b0,
           mk(1'b1, 2'b00, 64'd0, 64'd0));
    chk_trap("fault", 1'b1, 16'h0C1F);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_trap("fault_hold", 1'b1, 16'h0C1F);
    end
    trapAck = 1'b1; tick(); trapAck = 1'b0;
    chk_trap("fault_ack", 1'b0, 16'h0000);

    run_op("fail1", CMD, {2'b00, IX_KRR}, 2'b11, 64'h5, 64'd0, 1'b0, mk(1'b1, 2'b00, 64'd0, 64'd0));
    run_op("fail2", CMD, {2'b00, IX_KRR}, 2'b01, 64'h6, 64'd0, 1'b0, mk(1'b1, 2'b00, 64'd0, 64'd0));
    chk_trap("fail_in_trap", 1'b1, 16'h0C1F);
    chk("cnt after 3 fails", {60'd0, krrFailCnt}, LOCKOUT ? 64'd3 : 64'd0);
    trapAck = 1'b1; tick(); trapAck = 1'b0;
    chk_trap("fail2_ack", 1'b0, 16'h0000);
    run_op("krr_ok2", CMD, {2'b00, IX_KRR}, 2'b10, 64'h42, 64'd0, 1'b0, mk(1'b1, 2'b10, 64'h42, 64'd0));
    chk("cnt cleared", {60'd0, krrFailCnt}, 64'd0);

    run_op("enc_a", CMD, {2'b00, IX_ENC}, 2'b00, a_dl, a_dh, 1'b0, mk(1'b1, 2'b00, a_dl, a_dh));
    exHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold valid", {63'd0, regOutValid}, 64'd1);
      chk("hold dlr", regOutDlr, a_dl);
    end
    exHold = 1'b0; tick();
    chk("hold release", {63'd0, regOutValid}, 64'd0);

    b_dh = 64'hFEEDFACE12345678;
    opUCmd = CMD; opUIxt = {2'b00, IX_ENC};
    tick();
    opUCmd = 8'd0; opUIxt = 8'd0; exHold = 1'b1;
    regInDlrE = {2'b00, 64'h31}; regInDhrE = {2'b00, b_dh};
    sb.push_back(mk(1'b1, 2'b00, 64'h31, b_dh));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("enc_hold valid", {63'd0, regOutValid}, 64'd0);
      chk("enc_hold dhr", regOutDhr, 64'd0);
    end
    exHold = 1'b0; tick();
    regInDlrE = '0; regInDhrE = '0;
    pop_check("enc_b");

    run_op("fail_a", CMD, {2'b00, IX_KRR}, 2'b00, 64'h1, 64'd0, 1'b0, mk(1'b1, 2'b00, 64'd0, 64'd0));
    chk_trap("fail_a", 1'b1, 16'h0C1F);
    run_op("fail_ack", CMD, {2'b00, IX_KRR}, 2'b00, 64'h2, 64'd0, 1'b1, mk(1'b1, 2'b00, 64'd0, 64'd0));
    chk_trap("fail_with_ack", 1'b1, 16'h0C1F);
    reset = 1'b1; exHold = 1'b1; tick(); reset = 1'b0; exHold = 1'b0;
    chk_trap("mid_fault_reset", 1'b0, 16'h0000);
    chk("reset cnt", {60'd0, krrFailCnt}, 64'd0);
    chk("reset valid", {63'd0, regOutValid}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op("seq_fail", CMD, {2'b00, IX_KRR}, 2'b00, 64'h10, 64'd0, 1'b0,
             mk(1'b1, 2'b00, 64'd0, 64'd0));
      chk_trap("seq_trap", 1'b1, (LOCKOUT && i == 7) ? 16'h0C1E : 16'h0C1F);
      chk("seq cnt", {60'd0, krrFailCnt}, LOCKOUT ? 64'(i + 1) : 64'd0);
      chk("seq locked", {63'd0, krrLocked}, (LOCKOUT && i == 7) ? 64'd1 : 64'd0);
      trapAck = 1'b1; tick(); trapAck = 1'b0;
      chk_trap("seq_ack", 1'b0, 16'h0000);
    end
    chk("post locked", {63'd0, krrLocked}, LOCKOUT ? 64'd1 : 64'd0);
    if (LOCKOUT) begin
      run_op("locked_krr", CMD, {2'b00, IX_KRR}, 2'b10, 64'h1122334455667788, 64'd0, 1'b0,
             mk(1'b1, 2'b00, 64'd0, 64'd0));
      chk_trap("locked_no_trap", 1'b0, 16'h0000);
      chk("locked cnt", {60'd0, krrFailCnt}, 64'd9);
      for (int i = 0; i < 7; i++)
        run_op("sat_fail", CMD, {2'b00, IX_KRR}, 2'b00, 64'h0, 64'd0, 1'b0,
               mk(1'b1, 2'b00, 64'd0, 64'd0));
      chk("sat cnt", {60'd0, krrFailCnt}, 64'd15);
    end else begin
      run_op("unlocked_krr", CMD, {2'b00, IX_KRR}, 2'b10, 64'h1122334455667788, 64'd0, 1'b0,
             mk(1'b1, 2'b10, 64'h1122334455667788, 64'd0));
      chk_trap("unlocked_no_trap", 1'b0, 16'h0000);
    end

    chk("sb drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
